// File: rtl/multiword_add_seq_pkg.sv
// Shared constants and FSM state type for the sequential multi-word adder.
package multiword_add_seq_pkg;

    localparam int DEF_SLICE = 4;                      // bits per slice (CLA width)
    localparam int DEF_WORDS = 4;                      // number of slices
    localparam int DEF_WIDTH = DEF_SLICE * DEF_WORDS;  // operand width

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:1] c;

    // Generate/propagate terms and fully expanded lookahead carries.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ {c[3], c[2], c[1], cin};
    end

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential multi-word adder: one CLA slice per clock, LS slice first.
//
// Handshake: start is sampled only while busy=0; at that edge a, b and cin
// are latched and busy rises. Exactly WORDS edges later done pulses for one
// cycle and sum/cout update together; they hold until the next completion.
// start while busy=1 is ignored.
module multiword_add_seq
    import multiword_add_seq_pkg::*;
#(
    parameter int SLICE = DEF_SLICE,
    parameter int WORDS = DEF_WORDS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [SLICE*WORDS-1:0]   a,
    input  logic [SLICE*WORDS-1:0]   b,
    input  logic                     cin,
    output logic                     busy,
    output logic                     done,
    output logic [SLICE*WORDS-1:0]   sum,
    output logic                     cout
);

    localparam int WIDTH = SLICE * WORDS;
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t            state;
    state_t            state_n;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [WIDTH-1:0]  psum;
    logic              carry;
    logic [SLICE-1:0]  slice_sum;
    logic              slice_cout;
    logic              last;

    // Operand registers shift right each RUN cycle, so the active slice is
    // always in the low bits; the partial sum fills from the top down and is
    // fully aligned after WORDS shifts.
    cla4_slice u_cla (
        .a    (a_r[SLICE-1:0]),
        .b    (b_r[SLICE-1:0]),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    assign last = (cnt == CW'(WORDS - 1));
    assign busy = (state == RUN);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (last)  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath: latch operands, step one slice per cycle, publish on completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            a_r   <= '0;
            b_r   <= '0;
            psum  <= '0;
            carry <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    a_r   <= a;
                    b_r   <= b;
                    carry <= cin;
                    cnt   <= '0;
                    psum  <= '0;
                end
            end else begin
                a_r   <= a_r >> SLICE;
                b_r   <= b_r >> SLICE;
                psum  <= {slice_sum, psum[WIDTH-1:SLICE]};
                carry <= slice_cout;
                cnt   <= cnt + CW'(1);
                if (last) begin
                    sum  <= {slice_sum, psum[WIDTH-1:SLICE]};
                    cout <= slice_cout;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule
